// File: rtl/aes_ctr_sched.sv
// aes_ctr_sched: two-channel session scheduler in front of a single AES-CTR engine.
// A granted channel's key is programmed (or reused), its IV loaded, then
// LEN blocks stream through the engine before the session closes.
module aes_ctr_sched #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch0_req_i,
  input  logic [127:0]     ch0_key_i,
  input  logic [127:0]     ch0_iv_i,
  input  logic [LEN_W-1:0] ch0_len_i,
  output logic             ch0_gnt_o,
  output logic             ch0_done_o,
  input  logic [127:0]     ch0_din_i,
  input  logic             ch0_din_valid_i,
  output logic             ch0_din_ready_o,
  output logic [127:0]     ch0_dout_o,
  output logic             ch0_dout_valid_o,
  input  logic             ch1_req_i,
  input  logic [127:0]     ch1_key_i,
  input  logic [127:0]     ch1_iv_i,
  input  logic [LEN_W-1:0] ch1_len_i,
  output logic             ch1_gnt_o,
  output logic             ch1_done_o,
  input  logic [127:0]     ch1_din_i,
  input  logic             ch1_din_valid_i,
  output logic             ch1_din_ready_o,
  output logic [127:0]     ch1_dout_o,
  output logic             ch1_dout_valid_o,
  output logic [127:0]     ctr_key_o,
  output logic             ctr_key_valid_o,
  input  logic             ctr_key_ready_i,
  output logic [127:0]     ctr_iv_o,
  output logic             ctr_iv_valid_o,
  output logic [127:0]     ctr_din_o,
  output logic             ctr_din_valid_o,
  input  logic             ctr_din_ready_i,
  input  logic [127:0]     ctr_dout_i,
  input  logic             ctr_dout_valid_i,
  output logic             busy_o
);

  typedef enum logic [2:0] {IDLE, KEY, KWAIT, IV, STREAM, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, done_q;
  logic             sel_q, last_q, key_loaded_q, kw_q;
  logic             key_vld_q, iv_vld_q, busy_q;
  logic [127:0]     key_q, iv_q, last_key_q;
  logic [LEN_W-1:0] len_q, in_cnt_q, out_cnt_q;

  logic             pick_vld, pick_ch, done_sel;
  logic [127:0]     pick_key, pick_iv;
  logic [LEN_W-1:0] pick_len;
  logic             stream, room, sel_dv, beat;
  logic [127:0]     sel_din;

  // Round-robin pick among live requests; a tie goes to the channel not served last.
  always_comb begin
    pick_vld = ch0_req_i | ch1_req_i;
    pick_ch  = 1'b0;
    if (ch0_req_i && ch1_req_i) pick_ch = ~last_q;
    else if (ch1_req_i)         pick_ch = 1'b1;
    pick_key = pick_ch ? ch1_key_i : ch0_key_i;
    pick_iv  = pick_ch ? ch1_iv_i  : ch0_iv_i;
    pick_len = pick_ch ? ch1_len_i : ch0_len_i;
  end

  // Next-state logic: empty sessions jump to DONE, a matching loaded key skips programming.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          if (pick_len == '0)                              state_d = DONE;
          else if (key_loaded_q && (pick_key == last_key_q)) state_d = IV;
          else                                               state_d = KEY;
        end
      end
      KEY:    if (ctr_key_ready_i) state_d = KWAIT;
      KWAIT:  if (kw_q && ctr_key_ready_i) state_d = IV;
      IV:     state_d = STREAM;
      STREAM: if (ctr_dout_valid_i && ((out_cnt_q + LEN_W'(1)) == len_q)) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A len==0 session reaches DONE straight from IDLE, before sel_q is loaded.
  assign done_sel = (state_q == IDLE) ? pick_ch : sel_q;

  // Session latches, counters, key cache and registered control pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q        <= '0;
      done_q       <= '0;
      sel_q        <= 1'b0;
      last_q       <= 1'b1;
      key_loaded_q <= 1'b0;
      kw_q         <= 1'b0;
      key_vld_q    <= 1'b0;
      iv_vld_q     <= 1'b0;
      busy_q       <= 1'b0;
      key_q        <= '0;
      iv_q         <= '0;
      last_key_q   <= '0;
      len_q        <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
    end else begin
      key_vld_q <= (state_q == KEY) && ctr_key_ready_i;
      iv_vld_q  <= (state_d == IV) && (state_q != IV);
      busy_q    <= (state_d != IDLE);
      kw_q      <= (state_q == KWAIT);
      done_q    <= (state_d == DONE) ? (done_sel ? 2'b10 : 2'b01) : 2'b00;
      if (state_q == IDLE && pick_vld) begin
        gnt_q <= pick_ch ? 2'b10 : 2'b01;
        sel_q <= pick_ch;
        key_q <= pick_key;
        iv_q  <= pick_iv;
        len_q <= pick_len;
      end
      if (state_q == KEY && ctr_key_ready_i) begin
        key_loaded_q <= 1'b1;
        last_key_q   <= key_q;
      end
      if (beat) in_cnt_q <= in_cnt_q + LEN_W'(1);
      if (stream && ctr_dout_valid_i) out_cnt_q <= out_cnt_q + LEN_W'(1);
      if (state_q == DONE) begin
        gnt_q     <= '0;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
        last_q    <= sel_q;
      end
    end
  end

  // Block data paths: granted channel to engine and back, gated once LEN beats are in.
  always_comb begin
    stream           = (state_q == STREAM);
    room             = (in_cnt_q < len_q);
    sel_din          = sel_q ? ch1_din_i : ch0_din_i;
    sel_dv           = sel_q ? ch1_din_valid_i : ch0_din_valid_i;
    ctr_din_valid_o  = stream & room & sel_dv;
    ctr_din_o        = stream ? sel_din : '0;
    beat             = ctr_din_valid_o & ctr_din_ready_i;
    ch0_din_ready_o  = stream & room & ctr_din_ready_i & gnt_q[0];
    ch1_din_ready_o  = stream & room & ctr_din_ready_i & gnt_q[1];
    ch0_dout_o       = gnt_q[0] ? ctr_dout_i : '0;
    ch1_dout_o       = gnt_q[1] ? ctr_dout_i : '0;
    ch0_dout_valid_o = stream & gnt_q[0] & ctr_dout_valid_i;
    ch1_dout_valid_o = stream & gnt_q[1] & ctr_dout_valid_i;
  end

  assign ctr_key_o       = key_q;
  assign ctr_key_valid_o = key_vld_q;
  assign ctr_iv_o        = iv_q;
  assign ctr_iv_valid_o  = iv_vld_q;
  assign ch0_gnt_o       = gnt_q[0];
  assign ch1_gnt_o       = gnt_q[1];
  assign ch0_done_o      = done_q[0];
  assign ch1_done_o      = done_q[1];
  assign busy_o          = busy_q;

endmodule
